ttfs_spike_engine: RTL and testbench

TTFS_SPIKE_ENGINE -- requirements
Module: ttfs_spike_engine

---
 rtl/ttfs_spike_engine.sv | 176 +++++++++++++++++
 tb/tb_ttfs_spike_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttfs_spike_engine.sv
// Time-to-first-spike engine: per-neuron spike-time memory shared between a bus port,
// a pushback port and a scan/clear engine that reports matching neurons through a FIFO.
`timescale 1ns/1ps
module ttfs_spike_engine #(
    parameter int N          = 256,
    parameter int TW         = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [31:0]                   addr_i,
    input  logic [31:0]                   wdata_i,
    output logic                          gnt_o,
    output logic                          rvalid_o,
    output logic [31:0]                   rdata_o,
    input  logic                          start_i,
    input  logic                          mode_i,
    input  logic [TW-1:0]                 tick_i,
    output logic                          busy_o,
    output logic                          done_o,
    input  logic                          pb_valid_i,
    input  logic [$clog2(N)-1:0]          pb_addr_i,
    output logic                          pb_ready_o,
    output logic                          overflow_o,
    input  logic                          fifo_rd_en_i,
    output logic [$clog2(N)-1:0]          fifo_rdata_o,
    output logic                          fifo_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int AW = $clog2(N);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] NEVER      = '1;
    localparam logic [FW:0]   FULL_COUNT = (FW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;

    logic [TW-1:0] mem [N];
    logic [TW-1:0] rd_q, tick_lat, pb_val, mem_wdata;
    logic [AW-1:0] idx, cmp_idx, pend_idx, push_idx, mem_addr;
    logic [AW-1:0] fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic mode_lat, cmp_valid, pend_valid, rvalid_q, bus_we_q, overflow_q;
    logic pb_go, pb_drop, cmp_match, push_req, fifo_full, push, pop, eng_go;
    logic mem_en, mem_we;
    logic unused_bits;

    assign unused_bits  = ^{addr_i, wdata_i};
    assign gnt_o        = req_i;
    assign pb_ready_o   = pb_valid_i & ~req_i;
    assign pb_go        = pb_valid_i & ~req_i;
    assign pb_val       = tick_i + TW'(1);
    assign pb_drop      = (pb_val == NEVER);
    assign rvalid_o     = rvalid_q;
    assign rdata_o      = (rvalid_q && !bus_we_q) ? 32'(rd_q) : 32'd0;
    assign overflow_o   = overflow_q;
    assign busy_o       = (state == RUN) || (state == DRAIN);
    assign done_o       = (state == DONE);

    // A match that cannot enter a full FIFO parks in the pending slot and stalls the scan.
    assign cmp_match    = cmp_valid && (rd_q == tick_lat);
    assign push_req     = pend_valid || cmp_match;
    assign push_idx     = pend_valid ? pend_idx : cmp_idx;
    assign fifo_full    = (fifo_count_o == FULL_COUNT);
    assign push         = push_req && !fifo_full;
    assign pop          = fifo_rd_en_i && (fifo_count_o != '0);
    assign eng_go       = (state == RUN) && !req_i && !pb_valid_i && !(push_req && fifo_full);
    assign fifo_empty_o = (fifo_count_o == '0);
    assign fifo_rdata_o = fifo_mem[rd_ptr];

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (req_i) begin
            mem_en    = 1'b1;
            mem_we    = we_i;
            mem_addr  = addr_i[AW+1:2];
            mem_wdata = wdata_i[TW-1:0];
        end else if (pb_valid_i) begin
            mem_en    = !pb_drop;
            mem_we    = 1'b1;
            mem_addr  = pb_addr_i;
            mem_wdata = pb_val;
        end else if (eng_go) begin
            mem_en    = 1'b1;
            mem_we    = mode_lat;
            mem_addr  = idx;
            mem_wdata = NEVER;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        rd_q <= mem[mem_addr];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rvalid_q   <= 1'b0;
            bus_we_q   <= 1'b0;
            cmp_valid  <= 1'b0;
            cmp_idx    <= '0;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            overflow_q <= 1'b0;
        end else begin
            rvalid_q  <= req_i;
            bus_we_q  <= we_i;
            cmp_valid <= eng_go && !mode_lat;
            cmp_idx   <= idx;
            if (push_req && fifo_full) begin
                pend_valid <= 1'b1;
                pend_idx   <= push_idx;
            end else if (push) begin
                pend_valid <= 1'b0;
            end
            if (pb_go && pb_drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= IDLE;
            idx      <= '0;
            tick_lat <= '0;
            mode_lat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        tick_lat <= tick_i;
                        mode_lat <= mode_i;
                        idx      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (eng_go) begin
                        if (idx == AW'(N-1)) state <= DRAIN;
                        else                 idx   <= idx + AW'(1);
                    end
                end
                DRAIN: begin
                    if (!cmp_valid && !pend_valid) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count_o <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_idx;
                wr_ptr           <= wr_ptr + FW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + FW'(1);
            case ({push, pop})
                2'b10:   fifo_count_o <= fifo_count_o + (FW+1)'(1);
                2'b01:   fifo_count_o <= fifo_count_o - (FW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ttfs_spike_engine.sv
// Directed bench for ttfs_spike_engine: table of bus/pushback vectors plus scan,
// backpressure, arbitration, reset and restart sequences.
`timescale 1ns/1ps
module tb_ttfs_spike_engine;
    localparam int N  = 256;
    localparam int TW = 8;
    localparam int FD = 16;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        req_i, we_i, start_i, mode_i, pb_valid_i, fifo_rd_en_i;
    logic [31:0] addr_i, wdata_i;
    logic [TW-1:0] tick_i;
    logic [7:0]  pb_addr_i;
    logic        gnt_o, rvalid_o, busy_o, done_o, pb_ready_o, overflow_o, fifo_empty_o;
    logic [31:0] rdata_o;
    logic [7:0]  fifo_rdata_o;
    logic [4:0]  fifo_count_o;

    ttfs_spike_engine #(.N(N), .TW(TW), .FIFO_DEPTH(FD)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .start_i(start_i), .mode_i(mode_i), .tick_i(tick_i),
        .busy_o(busy_o), .done_o(done_o),
        .pb_valid_i(pb_valid_i), .pb_addr_i(pb_addr_i),
        .pb_ready_o(pb_ready_o), .overflow_o(overflow_o),
        .fifo_rd_en_i(fifo_rd_en_i), .fifo_rdata_o(fifo_rdata_o),
        .fifo_empty_o(fifo_empty_o), .fifo_count_o(fifo_count_o)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int ref_busy;

    always @(negedge CLK) begin
        if (done_o) done_cnt++;
        if (busy_o) busy_cnt++;
    end

    typedef struct {
        bit          is_pb;
        logic [7:0]  tick;
        int          idx;
        logic [31:0] wdata;
        logic [31:0] exp;
        bit          exp_ovf;
    } vec_t;
    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input int idx, input logic [31:0] d);
        @(negedge CLK);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'(idx) << 2; wdata_i = d;
        #1 checkOutput("wr_gnt", 32'(gnt_o), 32'd1);
        @(negedge CLK);
        req_i = 1'b0; we_i = 1'b0;
        checkOutput("wr_rvalid", 32'(rvalid_o), 32'd1);
        checkOutput("wr_rdata", rdata_o, 32'd0);
    endtask

    task automatic bus_read(input int idx, output logic [31:0] d);
        @(negedge CLK);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'(idx) << 2;
        @(negedge CLK);
        req_i = 1'b0;
        checkOutput("rd_rvalid", 32'(rvalid_o), 32'd1);
        d = rdata_o;
    endtask

    task automatic start_scan(input logic m, input logic [TW-1:0] t);
        @(negedge CLK);
        start_i = 1'b1; mode_i = m; tick_i = t;
        @(negedge CLK);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        repeat (4) @(negedge CLK);
        checkOutput("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    task automatic pop_expect(input string name, input int exp);
        @(negedge CLK);
        checkOutput({name, "_nonempty"}, 32'(fifo_empty_o), 32'd0);
        checkOutput(name, 32'(fifo_rdata_o), 32'(exp));
        fifo_rd_en_i = 1'b1;
        @(negedge CLK);
        fifo_rd_en_i = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        if (!v.is_pb) begin
            bus_write(v.idx, v.wdata);
        end else begin
            @(negedge CLK);
            tick_i = v.tick; pb_valid_i = 1'b1; pb_addr_i = 8'(v.idx);
            #1 checkOutput("pb_ready", 32'(pb_ready_o), 32'd1);
            @(negedge CLK);
            pb_valid_i = 1'b0;
        end
    endtask

    task automatic check_reset_values();
        checkOutput("rst_rvalid", 32'(rvalid_o), 32'd0);
        checkOutput("rst_rdata", rdata_o, 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_done", 32'(done_o), 32'd0);
        checkOutput("rst_overflow", 32'(overflow_o), 32'd0);
        checkOutput("rst_empty", 32'(fifo_empty_o), 32'd1);
        checkOutput("rst_count", 32'(fifo_count_o), 32'd0);
        checkOutput("rst_fifo_rdata", 32'(fifo_rdata_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  held;

        vecs[0] = '{1'b0, 8'd0,   5,   32'hDEADBE42, 32'h42, 1'b0};
        vecs[1] = '{1'b0, 8'd0,   255, 32'h12345678, 32'h78, 1'b0};
        vecs[2] = '{1'b1, 8'd9,   17,  32'h0,        32'd10, 1'b0};
        vecs[3] = '{1'b1, 8'd0,   0,   32'h0,        32'd1,  1'b0};
        vecs[4] = '{1'b1, 8'd253, 1,   32'h0,        32'd254, 1'b0};
        vecs[5] = '{1'b1, 8'd254, 17,  32'h0,        32'd10, 1'b1};
        vecs[6] = '{1'b1, 8'd100, 3,   32'h0,        32'd101, 1'b1};

        RSTN = 1'b1;
        req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0; start_i = 0; mode_i = 0;
        tick_i = 0; pb_valid_i = 0; pb_addr_i = 0; fifo_rd_en_i = 0;
        #2 RSTN = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_values();
        RSTN = 1'b1;

        // Clear, seed two spikes at tick 5, scan for them
        done_cnt = 0;
        start_scan(1'b1, 8'd0);
        wait_done(600);
        bus_write(3, 32'd5);
        bus_write(200, 32'd5);
        done_cnt = 0; busy_cnt = 0;
        start_scan(1'b0, 8'd5);
        wait_done(600);
        ref_busy = busy_cnt;
        checkOutput("scan_busy_min", 32'(ref_busy >= N + 1), 32'd1);
        checkOutput("scan_count", 32'(fifo_count_o), 32'd2);
        pop_expect("scan_first", 3);
        pop_expect("scan_second", 200);
        @(negedge CLK);
        checkOutput("scan_empty", 32'(fifo_empty_o), 32'd1);

        // Bus and blocked pushback hold memory for 10 cycles mid-scan
        done_cnt = 0; busy_cnt = 0;
        start_scan(1'b0, 8'd5);
        repeat (50) @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge CLK);
            if (i > 0) begin
                checkOutput("arb_rvalid", 32'(rvalid_o), 32'd1);
                checkOutput("arb_rdata", rdata_o, 32'd5);
            end
            req_i = 1'b1; we_i = 1'b0; addr_i = 32'd3 << 2;
            pb_valid_i = 1'b1; pb_addr_i = 8'd9;
            #1;
            checkOutput("arb_gnt", 32'(gnt_o), 32'd1);
            checkOutput("arb_pb_ready", 32'(pb_ready_o), 32'd0);
        end
        @(negedge CLK);
        checkOutput("arb_rvalid_last", 32'(rvalid_o), 32'd1);
        checkOutput("arb_rdata_last", rdata_o, 32'd5);
        req_i = 1'b0; pb_valid_i = 1'b0;
        wait_done(800);
        checkOutput("arb_busy_stretch", 32'(busy_cnt), 32'(ref_busy + 10));
        pop_expect("arb_first", 3);
        pop_expect("arb_second", 200);
        bus_read(9, d);
        checkOutput("arb_pb_blocked", d, 32'hFF);

        // Asynchronous reset in the middle of a scan
        done_cnt = 0;
        start_scan(1'b0, 8'd5);
        repeat (101) @(negedge CLK);
        RSTN = 1'b0;
        #1 check_reset_values();
        @(negedge CLK);
        RSTN = 1'b1;
        done_cnt = 0;
        start_scan(1'b0, 8'd5);
        wait_done(600);
        pop_expect("rst_rescan_first", 3);
        pop_expect("rst_rescan_second", 200);

        // A second start while running (as a clear) must be ignored
        done_cnt = 0;
        start_scan(1'b0, 8'd5);
        repeat (20) @(negedge CLK);
        start_scan(1'b1, 8'd0);
        wait_done(600);
        repeat (10) @(negedge CLK);
        checkOutput("restart_single_done", 32'(done_cnt), 32'd1);
        checkOutput("restart_count", 32'(fifo_count_o), 32'd2);
        pop_expect("restart_first", 3);
        pop_expect("restart_second", 200);
        bus_read(3, d);
        checkOutput("restart_not_cleared", d, 32'd5);

        // Table of bus writes and pushbacks with read-back
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            bus_read(vecs[i].idx, d);
            checkOutput($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
            checkOutput($sformatf("vec%0d_overflow", i), 32'(overflow_o), 32'(vecs[i].exp_ovf));
        end

        // FIFO backpressure: 20 matches into a 16-deep FIFO
        done_cnt = 0;
        start_scan(1'b1, 8'd0);
        wait_done(600);
        for (int i = 0; i < 20; i++) bus_write(10 * i + 5, 32'd7);
        done_cnt = 0;
        start_scan(1'b0, 8'd7);
        repeat (400) @(negedge CLK);
        checkOutput("bp_count_full", 32'(fifo_count_o), 32'd16);
        checkOutput("bp_stalled_busy", 32'(busy_o), 32'd1);
        checkOutput("bp_no_done", 32'(done_cnt), 32'd0);
        for (int i = 0; i < 4; i++) pop_expect($sformatf("bp_pop%0d", i), 10 * i + 5);
        wait_done(800);
        checkOutput("bp_count_after", 32'(fifo_count_o), 32'd16);
        for (int i = 4; i < 20; i++) pop_expect($sformatf("bp_pop%0d", i), 10 * i + 5);
        @(negedge CLK);
        checkOutput("bp_empty", 32'(fifo_empty_o), 32'd1);
        held = fifo_rdata_o;
        fifo_rd_en_i = 1'b1;
        @(negedge CLK);
        fifo_rd_en_i = 1'b0;
        @(negedge CLK);
        checkOutput("empty_read_hold", 32'(fifo_rdata_o), 32'(held));
        checkOutput("empty_read_count", 32'(fifo_count_o), 32'd0);
        checkOutput("overflow_sticky", 32'(overflow_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
